// File: rtl/calc_sequencer_if.sv
// calc_sequencer keypad/datapath bundle.
// master = sequencer side, slave = keypad + datapath side.
interface calc_sequencer_if #(
  parameter int MAX_DIGITS = 4
) ();
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [3:0]    value;
  logic          key_valid;
  logic          tick;
  logic          reset;
  logic          digit_en;
  logic          sel_b;
  logic          chainA;
  logic          loadR;
  logic [1:0]    op;
  logic          IUAU;
  logic          entry;
  logic [CW-1:0] digit_cnt;
  logic          err;

  modport master (
    input  value, key_valid,
    output tick, reset, digit_en, sel_b, chainA, loadR,
    output op, IUAU, entry, digit_cnt, err
  );

  modport slave (
    output value, key_valid,
    input  tick, reset, digit_en, sel_b, chainA, loadR,
    input  op, IUAU, entry, digit_cnt, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator control: tick divider, key edge detect, FSM.
// Define CALC_CHAIN_EN to let A/B/C in SHOW chain the result into A.
module calc_sequencer #(
  parameter int DIV        = 100000,
  parameter int MAX_DIGITS = 4
) (
  input logic            clock,
  input logic            clearA,
  calc_sequencer_if.master bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER_A, S_ENTER_B, S_EXEC, S_SHOW
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          key_prev_q, key_prev_d;
  logic          reset_q, reset_d;
  logic          digit_en_q, digit_en_d;
  logic          sel_b_q, sel_b_d;
  logic          loadR_q, loadR_d;
  logic [1:0]    op_q, op_d;
  logic          iuau_q, iuau_d;
  logic          entry_q, entry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`ifdef CALC_CHAIN_EN
  logic          chain_q, chain_d;
`endif

  logic evt, is_digit, is_op, is_clr, is_eq, go_idle;

  assign evt      = tick_q & bus.key_valid & ~key_prev_q;
  assign is_digit = bus.value <= 4'd9;
  assign is_op    = (bus.value == 4'hA) || (bus.value == 4'hB) ||
                    (bus.value == 4'hC);
  assign is_clr   = bus.value == 4'hD;
  assign is_eq    = bus.value == 4'hF;

  // Free-running divider; tick fires the cycle after the wrap value.
  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d     = (div_q == DIV_LAST);
    key_prev_d = tick_q ? bus.key_valid : key_prev_q;
  end

  // Next state and registered outputs, evaluated only on ticks.
  always_comb begin
    state_d    = state_q;
    reset_d    = reset_q;
    digit_en_d = 1'b0;
    loadR_d    = 1'b0;
    sel_b_d    = sel_b_q;
    op_d       = op_q;
    iuau_d     = iuau_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    go_idle    = 1'b0;
`ifdef CALC_CHAIN_EN
    chain_d    = 1'b0;
`endif
    if (tick_q) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ENTER_A;
          reset_d = 1'b1;
          entry_d = 1'b1;
          sel_b_d = 1'b0;
          iuau_d  = 1'b0;
          cnt_d   = '0;
        end
        S_ENTER_A, S_ENTER_B: begin
          if (evt) begin
            unique case (1'b1)
              is_digit: begin
                if (cnt_q < MAX_CNT) begin
                  digit_en_d = 1'b1;
                  cnt_d      = cnt_q + 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              is_op: begin
                op_d    = 2'(bus.value - 4'hA);
                if (state_q == S_ENTER_A) begin
                  cnt_d   = '0;
                  sel_b_d = 1'b1;
                  state_d = S_ENTER_B;
                end
              end
              is_clr: go_idle = 1'b1;
              is_eq: begin
                if (state_q == S_ENTER_B) begin
                  state_d = S_EXEC;
                  entry_d = 1'b0;
                  loadR_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          state_d = S_SHOW;
          iuau_d  = 1'b1;
          entry_d = 1'b1;
        end
        S_SHOW: begin
          if (evt) begin
            unique case (1'b1)
              is_digit, is_clr: go_idle = 1'b1;
              is_op: begin
`ifdef CALC_CHAIN_EN
                chain_d = 1'b1;
                op_d    = 2'(bus.value - 4'hA);
                cnt_d   = '0;
                sel_b_d = 1'b1;
                iuau_d  = 1'b0;
                state_d = S_ENTER_B;
`endif
              end
              default: ;
            endcase
          end
        end
        default: go_idle = 1'b1;
      endcase
    end
    if (go_idle) begin
      state_d = S_IDLE;
      reset_d = 1'b0;
      entry_d = 1'b0;
      sel_b_d = 1'b0;
      iuau_d  = 1'b0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end

  // State and output registers; async clear cuts any in-flight pulse.
  always_ff @(posedge clock or negedge clearA) begin
    if (!clearA) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      tick_q     <= 1'b0;
      key_prev_q <= 1'b1;
      reset_q    <= 1'b0;
      digit_en_q <= 1'b0;
      sel_b_q    <= 1'b0;
      loadR_q    <= 1'b0;
      op_q       <= 2'b00;
      iuau_q     <= 1'b0;
      entry_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
`ifdef CALC_CHAIN_EN
      chain_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      key_prev_q <= key_prev_d;
      reset_q    <= reset_d;
      digit_en_q <= digit_en_d;
      sel_b_q    <= sel_b_d;
      loadR_q    <= loadR_d;
      op_q       <= op_d;
      iuau_q     <= iuau_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`ifdef CALC_CHAIN_EN
      chain_q    <= chain_d;
`endif
    end
  end

  assign bus.tick      = tick_q;
  assign bus.reset     = reset_q;
  assign bus.digit_en  = digit_en_q;
  assign bus.sel_b     = sel_b_q;
  assign bus.loadR     = loadR_q;
  assign bus.op        = op_q;
  assign bus.IUAU      = iuau_q;
  assign bus.entry     = entry_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.err       = err_q;
`ifdef CALC_CHAIN_EN
  assign bus.chainA    = chain_q;
`else
  assign bus.chainA    = 1'b0;
`endif
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (DIV=4, MAX_DIGITS=2).
// Expected digit pulses (operand select) are queued and popped by a monitor.
module tb_calc_sequencer;
  localparam int DIV = 4;
  localparam int MD  = 2;

  logic clock = 1'b0;
  logic clearA = 1'b0;
  always #5 clock = ~clock;

  calc_sequencer_if #(.MAX_DIGITS(MD)) bus ();

  calc_sequencer #(.DIV(DIV), .MAX_DIGITS(MD)) dut (
    .clock (clock),
    .clearA(clearA),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_dig = 0;
  int n_ld  = 0;
  int n_ch  = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every digit_en must match a queued expectation.
  always @(negedge clock) begin
    if (bus.digit_en === 1'b1) begin
      n_dig++;
      chk("digit_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("digit_sel_b", 32'(bus.sel_b), 32'(exp_q.pop_front()));
    end
    if (bus.loadR === 1'b1) n_ld++;
    if (bus.chainA === 1'b1) n_ch++;
    if ((bus.digit_en | bus.loadR | bus.chainA) === 1'b1)
      chk("pulse_overlap", 32'(bus.digit_en) + 32'(bus.loadR) + 32'(bus.chainA), 1);
  end

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      @(negedge clock);
      seen = (bus.tick === 1'b1);
    end
    chk("tick_seen", 32'(seen), 1);
  endtask

  task automatic press(input logic [3:0] key);
    bus.value     = key;
    bus.key_valid = 1'b1;
    repeat (2) wait_tick();
    bus.key_valid = 1'b0;
    repeat (2) wait_tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tick"},     32'(bus.tick), 0);
    chk({tag, "_reset"},    32'(bus.reset), 0);
    chk({tag, "_digit_en"}, 32'(bus.digit_en), 0);
    chk({tag, "_loadR"},    32'(bus.loadR), 0);
    chk({tag, "_chainA"},   32'(bus.chainA), 0);
    chk({tag, "_op"},       32'(bus.op), 0);
    chk({tag, "_sel_b"},    32'(bus.sel_b), 0);
    chk({tag, "_IUAU"},     32'(bus.IUAU), 0);
    chk({tag, "_entry"},    32'(bus.entry), 0);
    chk({tag, "_cnt"},      32'(bus.digit_cnt), 0);
    chk({tag, "_err"},      32'(bus.err), 0);
  endtask

  initial begin
    int k;
    bit seen;
    int d0;
    bus.value     = 4'h0;
    bus.key_valid = 1'b0;

    // Reset and tick cadence
    repeat (3) @(negedge clock);
    chk_reset("rst");
    clearA = 1'b1;
    k = 0; seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(negedge clock);
      k = i;
      seen = (bus.tick === 1'b1);
    end
    chk("first_tick_cycle", 32'(k), 4);
    @(negedge clock);
    chk("after_tick_reset", 32'(bus.reset), 1);
    chk("after_tick_entry", 32'(bus.entry), 1);
    k = 1; seen = 1'b0;
    for (int i = 2; i <= 12 && !seen; i++) begin
      @(negedge clock);
      k = i;
      seen = (bus.tick === 1'b1);
    end
    chk("tick_period", 32'(k), 4);

    // Basic calculation 1,2,A,3,F
    exp_q.push_back(1'b0); press(4'h1);
    exp_q.push_back(1'b0); press(4'h2);
    chk("basic_cnt_a", 32'(bus.digit_cnt), 2);
    press(4'hA);
    chk("basic_sel_b", 32'(bus.sel_b), 1);
    chk("basic_cnt_clr", 32'(bus.digit_cnt), 0);
    exp_q.push_back(1'b1); press(4'h3);
    press(4'hF);
    chk("basic_digits", 32'(n_dig), 3);
    chk("basic_loadR", 32'(n_ld), 1);
    chk("basic_op", 32'(bus.op), 0);
    chk("basic_IUAU", 32'(bus.IUAU), 1);
    chk("basic_entry", 32'(bus.entry), 1);

    // Chain from SHOW with B
    press(4'hB);
`ifdef CALC_CHAIN_EN
    chk("chain_pulse", 32'(n_ch), 1);
    chk("chain_op", 32'(bus.op), 1);
    chk("chain_sel_b", 32'(bus.sel_b), 1);
    chk("chain_IUAU", 32'(bus.IUAU), 0);
    chk("chain_cnt", 32'(bus.digit_cnt), 0);
`else
    chk("chain_pulse", 32'(n_ch), 0);
    chk("chain_op", 32'(bus.op), 0);
    chk("chain_IUAU", 32'(bus.IUAU), 1);
`endif
    press(4'hD);
    chk("clear_reset", 32'(bus.reset), 1);
    chk("clear_sel_b", 32'(bus.sel_b), 0);

    // Overflow 1,2,3 then D
    exp_q.push_back(1'b0); press(4'h1);
    exp_q.push_back(1'b0); press(4'h2);
    d0 = n_dig;
    press(4'h3);
    chk("ovf_no_pulse", 32'(n_dig - d0), 0);
    chk("ovf_cnt", 32'(bus.digit_cnt), 2);
    chk("ovf_err", 32'(bus.err), 1);
    press(4'hD);
    chk("ovf_err_clr", 32'(bus.err), 0);
    chk("ovf_cnt_clr", 32'(bus.digit_cnt), 0);

    // Held key: one event over 10 ticks
    d0 = n_dig;
    exp_q.push_back(1'b0);
    bus.value     = 4'h5;
    bus.key_valid = 1'b1;
    repeat (10) wait_tick();
    bus.key_valid = 1'b0;
    repeat (2) wait_tick();
    chk("held_one", 32'(n_dig - d0), 1);

    // Held across reset release: no event
    d0 = n_dig;
    bus.key_valid = 1'b1;
    clearA = 1'b0;
    repeat (3) @(negedge clock);
    clearA = 1'b1;
    repeat (10) wait_tick();
    bus.key_valid = 1'b0;
    repeat (2) wait_tick();
    chk("held_reset_none", 32'(n_dig - d0), 0);
    chk("held_reset_cnt", 32'(bus.digit_cnt), 0);

    // Mid-op reset in ENTER_B as digit 9 is sampled
    exp_q.push_back(1'b0); press(4'h7);
    press(4'hA);
    chk("mid_sel_b", 32'(bus.sel_b), 1);
    d0 = n_dig;
    @(negedge clock);
    bus.value     = 4'h9;
    bus.key_valid = 1'b1;
    wait_tick();
    clearA = 1'b0;
    #1;
    chk_reset("mid");
    repeat (3) @(negedge clock);
    chk("mid_no_pulse", 32'(n_dig - d0), 0);
    bus.key_valid = 1'b0;
    clearA = 1'b1;
    @(negedge clock);
    chk("mid_idle_reset", 32'(bus.reset), 0);
    wait_tick();
    @(negedge clock);
    chk("mid_restart", 32'(bus.reset), 1);
    chk("mid_restart_entry", 32'(bus.entry), 1);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
